// File: rtl/vga_pkg.sv
// Shared VGA constants, pixel type and frame-buffer scheduler state encoding.
package vga_pkg;
  localparam int H_TOTAL   = 800;
  localparam int H_SYNC    = 96;
  localparam int H_BP      = 48;
  localparam int H_FP      = 16;
  localparam int V_TOTAL   = 525;
  localparam int V_SYNC    = 2;
  localparam int V_BP      = 33;
  localparam int V_FP      = 10;
  localparam int FB_PIXELS = 307200;

  typedef logic [29:0] pixel_t;

  typedef enum logic [1:0] {IDLE, RD_WAIT, WR_WAIT} mem_state_e;
endpackage

// File: rtl/vga_fb_fifo.sv
// Prefetch FIFO: DEPTH x W, synchronous flush, combinational head, level output.
module vga_fb_fifo #(
  parameter int DEPTH = 8,
  parameter int W     = 30
)(
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     push,
  input  logic [W-1:0]             din,
  input  logic                     pop,
  output logic [W-1:0]             dout,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic          do_push, do_pop;

  assign empty   = (level == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (level != FULL || do_pop);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk)
    if (do_push) mem[wr_ptr] <= din;

  // Flush beats any same-cycle push or pop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      level <= level + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end
endmodule

// File: rtl/vga_fb_sched.sv
// Frame-buffer scheduler: display prefetch vs host writes on one memory port.
// Optional underflow statistics counter enabled by VGA_FB_STATS_EN.
module vga_fb_sched
  import vga_pkg::*;
#(
  parameter int H_START    = 144,
  parameter int V_START    = 35,
  parameter int H_ACTIVE   = 640,
  parameter int V_ACTIVE   = 480,
  parameter int FIFO_DEPTH = 8,
  parameter int LOW_WM     = 3
)(
  input  logic        clk,
  input  logic        i_rst,
  input  logic        i_pix_en,
  input  logic [9:0]  i_h_count,
  input  logic [9:0]  i_v_count,
  output logic [9:0]  o_red,
  output logic [9:0]  o_green,
  output logic [9:0]  o_blue,
  output logic        o_de,
  output logic        o_mem_req,
  output logic        o_mem_we,
  output logic [18:0] o_mem_addr,
  output logic [29:0] o_mem_wdata,
  input  logic        i_mem_ack,
  input  logic [29:0] i_mem_rdata,
  input  logic        i_wr_valid,
  input  logic [18:0] i_wr_addr,
  input  logic [29:0] i_wr_data,
  output logic        o_wr_ready,
  output logic        o_underflow,
  output logic [15:0] o_underflow_cnt
);
  localparam int LW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [LW-1:0] LOW  = LW'(LOW_WM);
  localparam logic [LW-1:0] FULL = LW'(FIFO_DEPTH);
  localparam logic [9:0]  H_LO = 10'(H_START);
  localparam logic [9:0]  H_HI = 10'(H_START + H_ACTIVE);
  localparam logic [9:0]  V_LO = 10'(V_START);
  localparam logic [9:0]  V_HI = 10'(V_START + V_ACTIVE);
  // Fetch covers one frame of active pixels (all of memory at 640x480).
  localparam logic [18:0] FETCH_END = 19'(H_ACTIVE * V_ACTIVE);
  localparam logic [18:0] MEM_END   = 19'(FB_PIXELS);

  mem_state_e    state, state_n;
  logic [18:0]   fetch_addr, addr_n;
  logic          discard;
  logic [LW-1:0] level;
  logic          fifo_empty;
  pixel_t        fifo_dout, pix_q, wdata_n;
  logic          fs, active, pop, miss, push, rd_done;
  logic          fetch_ok, rd_lo, rd_hi, wr_go;
  logic          req_n, we_n, rdy_n;

  assign fs      = i_pix_en && i_h_count == '0 && i_v_count == '0;
  assign active  = i_pix_en && i_h_count >= H_LO && i_h_count < H_HI &&
                   i_v_count >= V_LO && i_v_count < V_HI;
  assign pop     = active && !fs;
  assign miss    = pop && fifo_empty;
  assign rd_done = state == RD_WAIT && i_mem_ack;
  assign push    = rd_done && !discard && !fs;

  vga_fb_fifo #(.DEPTH(FIFO_DEPTH), .W(30)) u_fifo (
    .clk   (clk),
    .rst   (i_rst),
    .flush (fs),
    .push  (push),
    .din   (i_mem_rdata),
    .pop   (pop),
    .dout  (fifo_dout),
    .empty (fifo_empty),
    .level (level)
  );

  // Decisions are only taken in IDLE, where no read is in flight, so level alone
  // is the precheck; no fetch on the FS cycle since fetch_addr is about to reset.
  assign fetch_ok = !fs && fetch_addr < FETCH_END;
  assign rd_lo    = fetch_ok && level < LOW;
  assign rd_hi    = fetch_ok && level < FULL;
  assign wr_go    = i_wr_valid && !o_wr_ready;

  always_comb begin
    state_n = state;
    req_n   = o_mem_req;
    we_n    = o_mem_we;
    addr_n  = o_mem_addr;
    wdata_n = o_mem_wdata;
    rdy_n   = 1'b0;
    case (state)
      IDLE: begin
        if (rd_lo || (!wr_go && rd_hi)) begin
          state_n = RD_WAIT;
          req_n   = 1'b1;
          we_n    = 1'b0;
          addr_n  = fetch_addr;
        end else if (wr_go) begin
          if (i_wr_addr < MEM_END) begin
            state_n = WR_WAIT;
            req_n   = 1'b1;
            we_n    = 1'b1;
            addr_n  = i_wr_addr;
            wdata_n = i_wr_data;
          end else begin
            rdy_n = 1'b1;
          end
        end
      end
      RD_WAIT: if (i_mem_ack) begin
        state_n = IDLE;
        req_n   = 1'b0;
      end
      WR_WAIT: if (i_mem_ack) begin
        state_n = IDLE;
        req_n   = 1'b0;
        we_n    = 1'b0;
        rdy_n   = 1'b1;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge i_rst) begin
    if (i_rst) begin
      state       <= IDLE;
      o_mem_req   <= 1'b0;
      o_mem_we    <= 1'b0;
      o_mem_addr  <= '0;
      o_mem_wdata <= '0;
      o_wr_ready  <= 1'b0;
      fetch_addr  <= '0;
      discard     <= 1'b0;
    end else begin
      state       <= state_n;
      o_mem_req   <= req_n;
      o_mem_we    <= we_n;
      o_mem_addr  <= addr_n;
      o_mem_wdata <= wdata_n;
      o_wr_ready  <= rdy_n;
      if (fs)        fetch_addr <= '0;
      else if (push) fetch_addr <= fetch_addr + 19'd1;
      if (rd_done)                    discard <= 1'b0;
      else if (fs && state == RD_WAIT) discard <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge i_rst) begin
    if (i_rst) begin
      pix_q       <= '0;
      o_de        <= 1'b0;
      o_underflow <= 1'b0;
    end else if (i_pix_en) begin
      pix_q <= (pop && !fifo_empty) ? fifo_dout : '0;
      o_de  <= active;
      if (miss) o_underflow <= 1'b1;
    end
  end

  assign o_red   = pix_q[29:20];
  assign o_green = pix_q[19:10];
  assign o_blue  = pix_q[9:0];

`ifdef VGA_FB_STATS_EN
  logic [15:0] uf_cnt;
  always_ff @(posedge clk or posedge i_rst) begin
    if (i_rst)                          uf_cnt <= '0;
    else if (miss && uf_cnt != 16'hFFFF) uf_cnt <= uf_cnt + 16'd1;
  end
  assign o_underflow_cnt = uf_cnt;
`else
  assign o_underflow_cnt = '0;
`endif
endmodule

// File: tb/tb_vga_fb_sched.sv
// Directed bench for vga_fb_sched with a small active window and a latency-controlled memory.
module tb_vga_fb_sched;
  import vga_pkg::*;

`ifdef VGA_FB_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic        clk = 1'b0, i_rst = 1'b1, i_pix_en = 1'b0;
  logic [9:0]  i_h_count = '0, i_v_count = '0;
  logic [9:0]  o_red, o_green, o_blue;
  logic        o_de, o_mem_req, o_mem_we, o_wr_ready, o_underflow;
  logic [18:0] o_mem_addr;
  logic [29:0] o_mem_wdata;
  logic        i_mem_ack = 1'b0;
  logic [29:0] i_mem_rdata = '0;
  logic        i_wr_valid = 1'b0;
  logic [18:0] i_wr_addr = '0;
  logic [29:0] i_wr_data = '0;
  logic [15:0] o_underflow_cnt;
  logic [29:0] rgb;

  int checks = 0, failures = 0;
  int lat = 1, cnt = 0;
  bit hold = 1'b0, force_en = 1'b0;
  logic        g_we   [1024];
  logic [18:0] g_addr [1024];
  logic [29:0] g_data [1024];
  int gcount = 0, rdy_cnt = 0;
  bit req_q = 1'b0;

  assign rgb = {o_red, o_green, o_blue};

  vga_fb_sched #(.H_ACTIVE(16), .V_ACTIVE(4)) dut (
    .clk(clk), .i_rst(i_rst), .i_pix_en(i_pix_en), .i_h_count(i_h_count), .i_v_count(i_v_count),
    .o_red(o_red), .o_green(o_green), .o_blue(o_blue), .o_de(o_de),
    .o_mem_req(o_mem_req), .o_mem_we(o_mem_we), .o_mem_addr(o_mem_addr), .o_mem_wdata(o_mem_wdata),
    .i_mem_ack(i_mem_ack), .i_mem_rdata(i_mem_rdata),
    .i_wr_valid(i_wr_valid), .i_wr_addr(i_wr_addr), .i_wr_data(i_wr_data), .o_wr_ready(o_wr_ready),
    .o_underflow(o_underflow), .o_underflow_cnt(o_underflow_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [29:0] pat(input logic [18:0] a);
    return {a[9:0], ~a[9:0], 10'h155};
  endfunction

  // Memory: ack after lat request cycles unless held; data is address-derived.
  always @(posedge clk) begin
    #1;
    if (i_mem_ack) begin
      i_mem_ack = 1'b0;
      cnt = 0;
    end else if (!o_mem_req) begin
      cnt = 0;
    end else if (!hold) begin
      cnt++;
      if (cnt >= lat) begin
        i_mem_ack   = 1'b1;
        i_mem_rdata = force_en ? 30'h3FFFFFFF : pat(o_mem_addr);
      end
    end
  end

  always @(posedge clk) begin
    #2;
    if (o_mem_req && !req_q && gcount < 1024) begin
      g_we[gcount]   = o_mem_we;
      g_addr[gcount] = o_mem_addr;
      g_data[gcount] = o_mem_wdata;
      gcount++;
    end
    req_q = o_mem_req;
    if (o_wr_ready) rdy_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic strobe(input int h, input int v);
    i_pix_en = 1'b1;
    i_h_count = 10'(h);
    i_v_count = 10'(v);
    @(negedge clk);
    i_pix_en = 1'b0;
  endtask

  initial begin
    int g, n, nwr, r0, idx;
    int ea [7] = '{9, 10, 100, 11, 101, 12, 102};
    bit ew [7] = '{0, 0, 1, 0, 1, 0, 1};

    // Reset state
    idle(2);
    chk("rst_req", 32'(o_mem_req), 0);
    chk("rst_we", 32'(o_mem_we), 0);
    chk("rst_addr", 32'(o_mem_addr), 0);
    chk("rst_wdata", 32'(o_mem_wdata), 0);
    chk("rst_rgb", 32'(rgb), 0);
    chk("rst_de", 32'(o_de), 0);
    chk("rst_rdy", 32'(o_wr_ready), 0);
    chk("rst_uf", 32'(o_underflow), 0);
    chk("rst_ufcnt", 32'(o_underflow_cnt), 0);
    i_rst = 1'b0;
    idle(3);
    chk("first_grant_cnt", 32'(gcount > 0), 1);
    chk("first_grant_we", 32'(g_we[0]), 0);
    chk("first_grant_addr", 32'(g_addr[0]), 0);
    idle(30);

    // Full frame of the 16x4 window: pixel k carries data of address k
    strobe(0, 0);
    idle(30);
    for (int v = 35; v < 39; v++) begin
      for (int h = 144; h < 160; h++) begin
        idx = (v - 35) * 16 + (h - 144);
        strobe(h, v);
        chk("frame_rgb", 32'(rgb), 32'(pat(19'(idx))));
        chk("frame_de", 32'(o_de), 1);
        idle(2);
      end
      if (v == 35) begin
        strobe(500, 35);
        chk("blank_rgb", 32'(rgb), 0);
        chk("blank_de", 32'(o_de), 0);
        idle(2);
      end
    end
    g = gcount;
    idle(20);
    chk("fetch_stop", 32'(gcount), 32'(g));
    chk("frame_uf", 32'(o_underflow), 0);

    // Host write flood: level 1 fetches first, then writes alternate with fetches
    strobe(0, 0);
    idle(30);
    hold = 1'b1;
    for (int i = 0; i < 8; i++) begin
      strobe(144 + i, 35);
      chk("drain_rgb", 32'(rgb), 32'(pat(19'(i))));
      idle(2);
    end
    g = gcount;
    r0 = rdy_cnt;
    i_wr_valid = 1'b1;
    i_wr_addr = 19'd100;
    i_wr_data = 30'h0ABCDE0;
    hold = 1'b0;
    nwr = 0;
    for (int c = 0; c < 100 && nwr < 3; c++) begin
      @(negedge clk);
      if (o_wr_ready) begin
        nwr++;
        i_wr_addr = i_wr_addr + 19'd1;
        i_wr_data = i_wr_data + 30'd1;
        if (nwr == 3) i_wr_valid = 1'b0;
      end
    end
    idle(6);
    chk("flood_ready", 32'(nwr), 3);
    chk("flood_ready_total", 32'(rdy_cnt - r0), 3);
    chk("flood_grants", 32'(gcount >= g + 7), 1);
    for (int k = 0; k < 7; k++) begin
      chk("flood_we", 32'(g_we[g + k]), 32'(ew[k]));
      chk("flood_addr", 32'(g_addr[g + k]), 32'(ea[k]));
      if (ew[k]) chk("flood_wdata", 32'(g_data[g + k]), 32'h0ABCDE0 + 32'((k - 2) / 2));
    end
    idle(30);

    // Slow memory: early active pixels underflow to black
    lat = 20;
    chk("pre_uf", 32'(o_underflow), 0);
    strobe(0, 0);
    for (int i = 0; i < 4; i++) begin
      strobe(144 + i, 35);
      chk("uf_rgb", 32'(rgb), 0);
      chk("uf_de", 32'(o_de), 1);
      idle(2);
    end
    chk("uf_flag", 32'(o_underflow), 1);
    chk("uf_cnt", 32'(o_underflow_cnt), STATS ? 4 : 0);
    idle(30);
    strobe(148, 35);
    chk("uf_recover_rgb", 32'(rgb), 32'(pat(19'd0)));
    idle(2);

    // FS while a read is outstanding; its late ack is discarded
    lat = 1;
    hold = 1'b1;
    n = 0;
    while (!(o_mem_req && !o_mem_we && !i_mem_ack) && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("rdwait_reached", 32'(n < 100), 1);
    strobe(0, 0);
    @(negedge clk);
    force_en = 1'b1;
    hold = 1'b0;
    n = 0;
    while (!i_mem_ack && n < 10) begin
      @(negedge clk);
      n++;
    end
    chk("discard_ack_seen", 32'(n < 10), 1);
    @(negedge clk);
    g = gcount;
    hold = 1'b1;
    force_en = 1'b0;
    strobe(144, 35);
    chk("discard_empty_rgb", 32'(rgb), 0);
    chk("discard_empty_de", 32'(o_de), 1);
    chk("discard_next_cnt", 32'(gcount), 32'(g + 1));
    chk("discard_next_we", 32'(g_we[g]), 0);
    chk("discard_next_addr", 32'(g_addr[g]), 0);
    hold = 1'b0;
    idle(4);
    strobe(145, 35);
    chk("discard_then_rgb", 32'(rgb), 32'(pat(19'd0)));
    chk("discard_ufcnt", 32'(o_underflow_cnt), STATS ? 5 : 0);
    idle(30);

    // Out-of-range host write: ready pulse, no memory request
    g = gcount;
    i_wr_valid = 1'b1;
    i_wr_addr = 19'(FB_PIXELS);
    i_wr_data = 30'h1;
    @(negedge clk);
    chk("oob_ready", 32'(o_wr_ready), 1);
    chk("oob_req", 32'(o_mem_req), 0);
    i_wr_valid = 1'b0;
    @(negedge clk);
    chk("oob_ready_drop", 32'(o_wr_ready), 0);
    chk("oob_no_grant", 32'(gcount), 32'(g));

    // Reset during a write transaction
    hold = 1'b1;
    i_wr_valid = 1'b1;
    i_wr_addr = 19'd5;
    i_wr_data = 30'h1234;
    n = 0;
    while (!(o_mem_req && o_mem_we) && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("wrwait_reached", 32'(n < 40), 1);
    chk("wr_bus_addr", 32'(o_mem_addr), 5);
    chk("wr_bus_data", 32'(o_mem_wdata), 32'h1234);
    i_rst = 1'b1;
    #1;
    chk("arst_req", 32'(o_mem_req), 0);
    chk("arst_rdy", 32'(o_wr_ready), 0);
    chk("arst_uf", 32'(o_underflow), 0);
    chk("arst_ufcnt", 32'(o_underflow_cnt), 0);
    @(negedge clk);
    i_rst = 1'b0;
    i_wr_valid = 1'b0;
    hold = 1'b0;
    g = gcount;
    idle(4);
    chk("post_rst_grant", 32'(gcount > g), 1);
    chk("post_rst_we", 32'(g_we[g]), 0);
    chk("post_rst_addr", 32'(g_addr[g]), 0);
    idle(30);
    strobe(0, 0);
    g = gcount;
    idle(6);
    chk("post_fs_grant", 32'(gcount > g), 1);
    chk("post_fs_we", 32'(g_we[g]), 0);
    chk("post_fs_addr", 32'(g_addr[g]), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/vga_fb_sched.md
# vga_fb_sched

Frame-buffer access scheduler for the 640x480 VGA display path. It shares one single-port pixel memory between real-time display fetch and a host write port. It prefetches pixels into a small FIFO ahead of the raster and delivers one RGB pixel per pixel strobe to the `vga` timing block's `display`/`displayg`/`displayb` inputs. Display fetch takes priority whenever the prefetch level is low; host writes use the remaining memory slots.

## Interface
Parameters:
- `H_START`, 144: first active h_count (HSYNC 96 + back porch 48).
- `V_START`, 35: first active v_count (VSYNC 2 + back porch 33).
- `H_ACTIVE`, 640: active pixels per line.
- `V_ACTIVE`, 480: active lines per frame.
- `FIFO_DEPTH`, 8: prefetch entries (power of two).
- `LOW_WM`, 3: below this level, fetch beats host writes.

Ports:
- `clk` in 1: single clock for all logic.
- `i_rst` in 1: reset, asynchronous, active-high.
- `i_pix_en` in 1: one-cycle strobe per pixel clock.
- `i_h_count` in 10: raster horizontal count from `vga`.
- `i_v_count` in 10: raster vertical count from `vga`.
- `o_red`, `o_green`, `o_blue` out 10 each: pixel to the `vga` display inputs.
- `o_de` out 1: the registered pixel is in the active area.
- `o_mem_req` out 1: memory request, held until ack.
- `o_mem_we` out 1: 1 = write, 0 = read.
- `o_mem_addr` out 19: pixel address, 0..307199.
- `o_mem_wdata` out 30: {R,G,B} write data.
- `i_mem_ack` in 1: completes the current request.
- `i_mem_rdata` in 30: read data, valid with ack.
- `i_wr_valid` in 1: host write request.
- `i_wr_addr` in 19: host pixel address.
- `i_wr_data` in 30: host {R,G,B}.
- `o_wr_ready` out 1: one-cycle pulse when the host write completes.
- `o_underflow` out 1: sticky; an active pixel found the FIFO empty.
- `o_underflow_cnt` out 16: see Configuration.

## Operation
- Frame start (FS) is `i_pix_en` with h=0 and v=0. On FS:
  - FIFO flushed.
  - Fetch address reset to 0.
  - A read in flight is marked discard.
- Active pixel: `i_pix_en` with `H_START` ≤ h < `H_START+H_ACTIVE` and `V_START` ≤ v < `V_START+V_ACTIVE`.
  - Active pixel: pop the FIFO and drive RGB with `o_de`=1.
  - Active pixel with the FIFO empty: drive black and set `o_underflow`.
  - Non-active strobe: drive black with `o_de`=0.
- Memory FSM:
  - IDLE: choose an action in priority order:
    - (a) fetch, if level + inflight < `LOW_WM` and fetch_addr < 307200;
    - (b) host write, if `i_wr_valid`;
    - (c) fetch, if level < `FIFO_DEPTH` and fetch_addr < 307200;
    - (d) otherwise stay in IDLE.
  - RD_WAIT: on ack, push rdata (unless discard), fetch_addr++, go to IDLE.
  - WR_WAIT: on ack, pulse `o_wr_ready`, go to IDLE.
- Fetch stops at address 307199 until the next FS. There is no wrap within a frame.
- A host write with `i_wr_addr` ≥ 307200 does not touch memory. `o_wr_ready` pulses the cycle after it is selected.
- Host write hold rule: addr and data must stay stable while `i_wr_valid` is high and before `o_wr_ready`.
- At most one memory transaction is outstanding.
- FIFO overflow is impossible by construction: the fetch precheck counts the in-flight read.

## Timing
- Reset values: all outputs 0; FSM in IDLE; FIFO empty; fetch_addr 0.
- `o_mem_req`/`o_mem_we`/`o_mem_addr`/`o_mem_wdata` are registered. They assert the cycle after the IDLE decision and hold until the cycle `i_mem_ack` is sampled high.
- `o_mem_req` drops the cycle after ack. Minimum transaction spacing is 2 clocks.
- The pushed data is poppable the cycle after ack.
- Pixel outputs are registered: 1 clk after the `i_pix_en` sample.
- Push and pop in the same cycle: level unchanged. If the FIFO is empty, pop sees underflow; it does not see the same-cycle push.
- FS and ack in the same cycle: the data is discarded and the FIFO is empty afterwards.
- FS and pop in the same cycle: flush wins.
- `i_rst` mid-transaction: `o_mem_req` clears immediately. Any late ack in IDLE is ignored.

## Configuration
- `VGA_FB_STATS_EN` defined:
  - `o_underflow_cnt` counts underflowed active pixels, saturating at 16'hFFFF.
  - It clears on reset only.
- Not defined: `o_underflow_cnt` is tied to 0 and the counter is removed. `o_underflow` is unaffected.

## Structure
- Shared package `vga_pkg`:
  - timing constants (800/525 totals, porches, sync widths);
  - `FB_PIXELS` = 307200;
  - the 30-bit pixel typedef;
  - the FSM state enum {IDLE, RD_WAIT, WR_WAIT}.
- Sub-module `vga_fb_fifo`:
  - synchronous FIFO with flush;
  - `FIFO_DEPTH` x 30;
  - level output.

## Test plan
- Reset, then FS with an ideal memory (ack 1 cycle after req) holding addr-indexed data. Check that the first active pixel (h=144, v=35) outputs data from addr 0, and pixel (h=783, v=514) outputs addr 307199. `o_underflow` stays 0.
- Host write flood (`i_wr_valid` always high) with the FIFO at level 1. Check the next grant is a read. At level ≥ `LOW_WM`, check writes alternate with fetches and every write gets exactly one `o_wr_ready`.
- Memory ack delayed 20 clocks. Check underflow: active pixels go black, `o_underflow`=1, and with `VGA_FB_STATS_EN` the counter equals the count of missed active pixels.
- FS while RD_WAIT, with ack 3 cycles later carrying 30'h3FFFFFFF. Check the FIFO is empty after the ack and the next read addr is 0.
- Host write to addr 307200. Check no `o_mem_req` with we=1 and an `o_wr_ready` pulse the cycle after selection.
- Assert `i_rst` during WR_WAIT. Check `o_mem_req`=0 and `o_wr_ready`=0 immediately; after release, the first request is a fetch at addr 0 after FS.
